// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: bubble instruction, stage payload struct
// and the register update-priority decode used by the stage registers.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

    localparam int XLEN_DEFAULT = 32;
    localparam int SB_W_DEFAULT = 1;

    // Default-width view of the Fetch/Decode payload, shared with later stage registers.
    typedef struct packed {
        logic                    valid;
        logic [XLEN_DEFAULT-1:0] instr;
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] pc_plus4;
        logic [SB_W_DEFAULT-1:0] sb;
    } if_id_t;

    typedef enum logic [1:0] {
        UPD_RESET,
        UPD_FLUSH,
        UPD_HOLD,
        UPD_LOAD
    } upd_e;

    // Reset beats flush, flush beats stall, otherwise the register loads.
    function automatic upd_e upd_sel(input logic rst, input logic flush, input logic stall);
        if (rst)        return UPD_RESET;
        else if (flush) return UPD_FLUSH;
        else if (stall) return UPD_HOLD;
        else            return UPD_LOAD;
    endfunction

endpackage

// File: rtl/fetch_decode_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_decode_pipe_reg.sv
// Fetch-to-Decode pipeline register with stall, flush-to-bubble and sideband.
// Define PIPE_PERF_CNT_EN to add saturating stall / squash counters and their ports.
module fetch_decode_pipe_reg
    import pipe_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          SB_WIDTH  = 1,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 ValidF,
    input  logic [WIDTH-1:0]     InstrF,
    input  logic [WIDTH-1:0]     PCF,
    input  logic [WIDTH-1:0]     PCPlus4F,
    input  logic [SB_WIDTH-1:0]  SbF,
    output logic                 ValidD,
    output logic [WIDTH-1:0]     InstrD,
    output logic [WIDTH-1:0]     PCD,
    output logic [WIDTH-1:0]     PCPlus4D,
`ifdef PIPE_PERF_CNT_EN
    output logic [SB_WIDTH-1:0]  SbD,
    output logic [CNT_WIDTH-1:0] StallCntD,
    output logic [CNT_WIDTH-1:0] SquashCntD
`else
    output logic [SB_WIDTH-1:0]  SbD
`endif
);

    // Width-parameterised form of pipe_pkg::if_id_t.
    typedef struct packed {
        logic                valid;
        logic [WIDTH-1:0]    instr;
        logic [WIDTH-1:0]    pc;
        logic [WIDTH-1:0]    pc_plus4;
        logic [SB_WIDTH-1:0] sb;
    } stage_t;

    localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_INSTR);

    localparam stage_t BUBBLE = '{
        valid:    1'b0,
        instr:    NOP_W,
        pc:       '0,
        pc_plus4: '0,
        sb:       '0
    };

    stage_t q_r;
    upd_e   upd;

    assign upd = upd_sel(rst, FlushD, StallD);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        case (upd)
            UPD_RESET, UPD_FLUSH: q_r <= BUBBLE;
            UPD_HOLD:             q_r <= q_r;
            default: begin
                // An invalid fetch is normalised to the bubble instruction.
                q_r <= '{
                    valid:    ValidF,
                    instr:    ValidF ? InstrF : NOP_W,
                    pc:       PCF,
                    pc_plus4: PCPlus4F,
                    sb:       SbF
                };
            end
        endcase
    end

    assign ValidD   = q_r.valid;
    assign InstrD   = q_r.instr;
    assign PCD      = q_r.pc;
    assign PCPlus4D = q_r.pc_plus4;
    assign SbD      = q_r.sb;

`ifdef PIPE_PERF_CNT_EN
    logic stall_inc;
    logic squash_inc;

    // A squash only counts when the flush discards a real instruction.
    assign stall_inc  = (upd == UPD_HOLD);
    assign squash_inc = (upd == UPD_FLUSH) && q_r.valid;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (StallCntD)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_squash_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (squash_inc),
        .count (SquashCntD)
    );
`endif

endmodule

// File: tb/tb_fetch_decode_pipe_reg.sv
// Self-checking bench for fetch_decode_pipe_reg: directed plan steps, then random
// traffic against a behavioural model. Counter checks apply when PIPE_PERF_CNT_EN is defined.
module tb_fetch_decode_pipe_reg;

    localparam int W    = 32;
    localparam int SBW  = 1;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [W-1:0] NOP = 32'h0000_0013;

    logic           clk      = 1'b0;
    logic           rst      = 1'b1;
    logic           StallD   = 1'b0;
    logic           FlushD   = 1'b0;
    logic           ValidF   = 1'b0;
    logic [W-1:0]   InstrF   = '0;
    logic [W-1:0]   PCF      = '0;
    logic [W-1:0]   PCPlus4F = '0;
    logic [SBW-1:0] SbF      = '0;

    logic           ValidD;
    logic [W-1:0]   InstrD;
    logic [W-1:0]   PCD;
    logic [W-1:0]   PCPlus4D;
    logic [SBW-1:0] SbD;
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0]  StallCntD;
    logic [CW-1:0]  SquashCntD;
`endif

    fetch_decode_pipe_reg #(
        .WIDTH     (W),
        .SB_WIDTH  (SBW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .ValidF     (ValidF),
        .InstrF     (InstrF),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .SbF        (SbF),
        .ValidD     (ValidD),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
`ifdef PIPE_PERF_CNT_EN
        .SbD        (SbD),
        .StallCntD  (StallCntD),
        .SquashCntD (SquashCntD)
`else
        .SbD        (SbD)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what Decode should hold, plus event tallies.
    logic           m_valid;
    logic [W-1:0]   m_instr;
    logic [W-1:0]   m_pc;
    logic [W-1:0]   m_pc4;
    logic [SBW-1:0] m_sb;
    int             m_stalls  = 0;
    int             m_squashes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_valid = 1'b0; m_instr = NOP; m_pc = '0; m_pc4 = '0; m_sb = '0;
            m_stalls = 0; m_squashes = 0;
        end else if (FlushD) begin
            if (m_valid) m_squashes = (m_squashes < CMAX) ? m_squashes + 1 : CMAX;
            m_valid = 1'b0; m_instr = NOP; m_pc = '0; m_pc4 = '0; m_sb = '0;
        end else if (StallD) begin
            m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
        end else begin
            m_valid = ValidF;
            m_instr = ValidF ? InstrF : NOP;
            m_pc    = PCF;
            m_pc4   = PCPlus4F;
            m_sb    = SbF;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, 64'(ValidD),   64'(m_valid));
        check({tag, ".instr"}, 64'(InstrD),   64'(m_instr));
        check({tag, ".pc"},    64'(PCD),      64'(m_pc));
        check({tag, ".pc4"},   64'(PCPlus4D), 64'(m_pc4));
        check({tag, ".sb"},    64'(SbD),      64'(m_sb));
`ifdef PIPE_PERF_CNT_EN
        check({tag, ".stallcnt"},  64'(StallCntD),  64'(m_stalls));
        check({tag, ".squashcnt"}, 64'(SquashCntD), 64'(m_squashes));
`endif
    endtask

    // Model the edge from the inputs as currently driven, then sample 1 time unit later.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic drive_random();
        ValidF   = ($urandom_range(0, 3) != 0);
        InstrF   = $urandom;
        PCF      = $urandom;
        PCPlus4F = PCF + 32'd4;
        SbF      = SBW'($urandom);
    endtask

    initial begin
        // Reset for two cycles with arbitrary inputs.
        rst = 1'b1;
        drive_random();
        StallD = 1'b1;
        tick("reset0");
        drive_random();
        tick("reset1");
        check("reset.instr_lit", 64'(InstrD), 64'h13);
        check("reset.valid_lit", 64'(ValidD), 64'h0);

        // Plain load.
        rst = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        ValidF = 1'b1; InstrF = 32'h0050_0093; PCF = 32'h100; PCPlus4F = 32'h104; SbF = 1'b1;
        tick("load");
        check("load.instr_lit", 64'(InstrD), 64'h0050_0093);
        check("load.pc_lit",    64'(PCD),    64'h100);

        // Three-cycle stall while Fetch moves on.
        StallD = 1'b1; PCF = 32'h104; PCPlus4F = 32'h108;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall.pc_lit", 64'(PCD), 64'h100);
        end
`ifdef PIPE_PERF_CNT_EN
        check("stall.cnt_lit", 64'(StallCntD), 64'd3);
`endif
        StallD = 1'b0;
        tick("unstall");
        check("unstall.pc_lit", 64'(PCD), 64'h104);

        // Flush together with stall discards the valid instruction.
        StallD = 1'b1; FlushD = 1'b1;
        tick("flushstall");
        check("flushstall.valid_lit", 64'(ValidD), 64'h0);
        check("flushstall.instr_lit", 64'(InstrD), 64'h13);
`ifdef PIPE_PERF_CNT_EN
        check("flushstall.squash_lit", 64'(SquashCntD), 64'd1);
`endif
        FlushD = 1'b0;
        tick("holdbubble");
        check("holdbubble.valid_lit", 64'(ValidD), 64'h0);

        // Invalid fetch loads a normalised bubble but still captures the PC.
        StallD = 1'b0; ValidF = 1'b0; InstrF = 32'hFFFF_FFFF; PCF = 32'h200; PCPlus4F = 32'h204;
        tick("invalid");
        check("invalid.instr_lit", 64'(InstrD), 64'h13);
        check("invalid.pc_lit",    64'(PCD),    64'h200);

        // Random traffic, including occasional mid-run resets.
        for (int i = 0; i < 300; i++) begin
            rst    = ($urandom_range(0, 49) == 0);
            FlushD = ($urandom_range(0, 4) == 0);
            StallD = ($urandom_range(0, 2) == 0);
            drive_random();
            tick("random");
        end

        // Counter saturation: 20 consecutive stall cycles from reset.
        rst = 1'b1; FlushD = 1'b0; StallD = 1'b0;
        tick("satreset");
        rst = 1'b0; StallD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_random();
            tick("saturate");
        end
`ifdef PIPE_PERF_CNT_EN
        check("saturate.cnt_lit", 64'(StallCntD), 64'hF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_decode_pipe_reg.md
# fetch_decode_pipe_reg

Parametrised Fetch-to-Decode pipeline register with stall (hold), flush (bubble insertion), a valid bit and a configurable sideband payload. Sits between the Fetch and Decode stages of the pipelined core. The hazard unit drives stall and flush. Optional saturating performance counters report stall and squash activity.

## Interface
Parameters:
- WIDTH, 32, width of the instruction and PC datapath.
- SB_WIDTH, 1, sideband width, e.g. a branch-predicted-taken bit; minimum 1.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0), truncated or zero-extended to WIDTH.
- CNT_WIDTH, 16, performance counter width; used only with PIPE_PERF_CNT_EN.

Ports:
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- StallD, input, 1, hold the current contents.
- FlushD, input, 1, replace the contents with a bubble.
- ValidF, input, 1, Fetch presents a real instruction.
- InstrF, input, WIDTH, fetched instruction.
- PCF, input, WIDTH, fetch PC.
- PCPlus4F, input, WIDTH, fetch PC + 4.
- SbF, input, SB_WIDTH, sideband from Fetch.
- ValidD, output, 1, Decode holds a real instruction.
- InstrD, output, WIDTH, registered instruction.
- PCD, output, WIDTH, registered PC.
- PCPlus4D, output, WIDTH, registered PC + 4.
- SbD, output, SB_WIDTH, registered sideband.
- StallCntD, output, CNT_WIDTH, stall-cycle count; present only with PIPE_PERF_CNT_EN.
- SquashCntD, output, CNT_WIDTH, squashed-instruction count; present only with PIPE_PERF_CNT_EN.

## Operation
- Update priority on each rising edge: rst > FlushD > StallD > load.
- rst: ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, SbD=0, both counters 0.
- Flush (FlushD=1, regardless of StallD):
  - Same values as reset for the datapath and valid bit.
  - Counters are not cleared.
- Stall (StallD=1, FlushD=0): every output register holds its value; no Fetch input is sampled.
- Load (StallD=0, FlushD=0):
  - ValidD<=ValidF.
  - InstrD<=ValidF ? InstrF : NOP_INSTR. This normalises bubbles so Decode never sees garbage.
  - PCD, PCPlus4D and SbD are captured unconditionally.
- No combinational path from any input to any output; all outputs are direct register outputs.
- No state machine beyond the valid bit: the register holds a bubble (ValidD=0) or an instruction (ValidD=1).

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Stall asserted for k consecutive cycles: the outputs are frozen for exactly k edges. The load resumes on the first edge with StallD=0.
- Flush and stall in the same cycle: flush wins; the stage is a bubble after the edge. If the stall continues, the bubble is held.
- Reset mid-operation, e.g. during a stall: reset values appear after the first edge with rst=1.
- Counters are saturating: they stop at all-ones and never wrap.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - StallCntD increments on each edge with rst=0, FlushD=0, StallD=1.
  - SquashCntD increments on each edge with rst=0, FlushD=1, ValidD=1, i.e. a real instruction is discarded.
  - Both counters saturate.
- PIPE_PERF_CNT_EN undefined:
  - Counter logic and the StallCntD and SquashCntD ports are absent.
  - Datapath behaviour is identical.

## Structure
- Shared package pipe_pkg:
  - NOP_INSTR default constant.
  - typedef struct packed if_id_t {valid, instr, pc, pc_plus4, sb}, used by this block and later stage registers.
- Sub-module sat_counter, parameter CNT_WIDTH, ports clk, rst, inc, count; instantiated twice under PIPE_PERF_CNT_EN.

## Test plan
- Reset: rst=1 for 2 cycles with arbitrary inputs -> ValidD=0, InstrD=32'h13, PCD=0, PCPlus4D=0, SbD=0, counters 0.
- Load: ValidF=1, InstrF=32'h00500093, PCF=32'h100, PCPlus4F=32'h104, SbF=1 -> the same values appear on the D outputs one edge later, ValidD=1.
- Stall: load as above, then StallD=1 for 3 cycles while the inputs change to PCF=32'h104 -> PCD stays 32'h100 for 3 edges, then becomes 32'h104. StallCntD=3 with the macro.
- Flush and stall together: ValidD=1, StallD=1, FlushD=1 -> ValidD=0 and InstrD=32'h13 after the edge; SquashCntD=1. Holding StallD=1 with FlushD=0 keeps the bubble.
- Invalid fetch: ValidF=0, InstrF=32'hFFFFFFFF, PCF=32'h200 -> ValidD=0, InstrD=32'h13, PCD=32'h200.
- Saturation: CNT_WIDTH=4, StallD=1 for 20 cycles -> StallCntD reaches 4'hF and stays there.
